ram_arb: RTL

- Two-master, one-slave arbiter that shares the RAM port between the CPU (master 0) and the video refresh fetcher (master 1).
- Sits between the address decoder's RAM strobe and the RAM instance.
- Each master sees a plain stb/we/addr/data/ack bus.
- Arbitration is registered, with round-robin or master-1-priority policy, plus a starvation guard for master 0.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_pick.sv | 33 +++
 rtl/ram_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-master RAM arbiter: FSM states, master indices
// and the width of the master-0 starvation counter.
package ram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int WAIT_W = 4;

    function automatic logic [1:0] gnt_state(input logic master);
        return (master == M1) ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the RAM arbiter, evaluated only while idle.
// Ties go round-robin, or to master 1 unless master 0 has been starved MAX_WAIT times.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int PRIO1    = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_m0_stb,
    input  logic              i_m1_stb,
    input  logic              i_last,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_req,
    output logic              o_win
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    always_comb begin
        o_req = i_m0_stb | i_m1_stb;
        o_win = M0;
        if (i_m0_stb && i_m1_stb) begin
            if (PRIO1 != 0) begin
                o_win = (i_wait_cnt == MAX_W) ? M0 : M1;
            end else begin
                o_win = ~i_last;
            end
        end else if (i_m1_stb) begin
            o_win = M1;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Two-master (CPU, video fetcher) arbiter in front of the single RAM port.
// Registered grant, combinational bus mux while granted, one IDLE cycle between grants.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int PRIO1    = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    output logic [DW-1:0]     m0_rdata,
    output logic              m0_ack,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    output logic [DW-1:0]     m1_rdata,
    output logic              m1_ack,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_ack,
    output logic [1:0]        o_dbg_state,
    output logic              o_dbg_last,
    output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic [1:0]        r_state;
    logic              r_last;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic w_req;
    logic w_win;
    logic w_cur_stb;

    ram_arb_pick #(
        .PRIO1    (PRIO1),
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_m0_stb   (m0_stb),
        .i_m1_stb   (m1_stb),
        .i_last     (r_last),
        .i_wait_cnt (r_wait_cnt),
        .o_req      (w_req),
        .o_win      (w_win)
    );

    assign w_cur_stb = (r_state == ST_GNT1) ? m1_stb : m0_stb;

    // Handshake: a master raises stb and holds we/addr/wdata until it sees ack
    // for one cycle; ack and rdata come straight from the slave while granted.
    always_comb begin
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (r_state)
            ST_GNT0: begin
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                m0_ack   = s_ack;
                m0_rdata = s_rdata;
            end
            ST_GNT1: begin
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                m1_ack   = s_ack;
                m1_rdata = s_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= M1;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= gnt_state(w_win);
                        if (w_win == M0) begin
                            r_wait_cnt <= '0;
                        end else if (PRIO1 != 0 && m0_stb && r_wait_cnt != MAX_W) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    // A dropped strobe without ack is an abort: last stays as it was.
                    if (s_ack) begin
                        r_state <= ST_IDLE;
                        r_last  <= (r_state == ST_GNT1) ? M1 : M0;
                    end else if (!w_cur_stb) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dbg_state    = r_state;
    assign o_dbg_last     = r_last;
    assign o_dbg_wait_cnt = r_wait_cnt;

endmodule
